// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: encodings shared by the memory port arbiter and its users.
// Holds the arbiter state encoding, the memory access size codes and the
// grant decision taken whenever the shared port is free.
package mem_port_arbiter_pkg;

    // Width of instruction words, store data and load data.
    localparam int unsigned DATA_W = 32;

    // Arbiter state: which requester (if any) owns the shared memory port.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_IF_BUSY = 2'b01,
        ARB_DM_BUSY = 2'b10
    } arb_state_e;

    // Access size codes as seen on dm_size and mem_size.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_e;

    // Owner chosen while the port is free. Data wins a tie unless the fetch side
    // has been passed over too often and is being forced through.
    function automatic arb_state_e arb_pick(input logic if_req,
                                            input logic dm_req,
                                            input logic if_forced);
        arb_state_e pick;
        if (if_req && (!dm_req || if_forced)) begin
            pick = ARB_IF_BUSY;
        end else if (dm_req) begin
            pick = ARB_DM_BUSY;
        end else begin
            pick = ARB_IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction-fetch
// requester and a data requester, with exactly one access in flight.
//
// Timing: the grant is decided in an IDLE cycle, the access runs in IF_BUSY or
// DM_BUSY until mem_ready, and the owner's valid pulse appears in the following
// IDLE cycle. That valid cycle is also where the next grant is decided, so
// back-to-back accesses are separated by exactly one IDLE cycle; a requester
// that wants no further access must have its request low in its valid cycle.
//
// Optional feature (macro MEM_ARB_STARVE_GUARD_EN): counts data grants issued
// while a fetch is waiting and forces a fetch grant once STARVE_MAX is reached.
// Without the macro the arbiter is pure data priority and has no counter.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    // Instruction fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,

    // Data side
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [1:0]        dm_size,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,

    // Shared memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be at least 1");
    end

    arb_state_e        state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;

    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic              grant_if;
    logic              grant_dm;
    logic              if_done;
    logic              dm_done;
    logic              starve_force;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Count data grants that overtake a waiting fetch; a fetch grant clears it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_if) begin
            starve_cnt_d = '0;
        end else if (grant_dm && if_req && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve_force = (starve_cnt_q == CNT_W'(STARVE_MAX));
`else
    assign starve_force = 1'b0;
`endif

    // FSM state register; a low reset also drops any access in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: grant from IDLE, return to IDLE when memory completes.
    // mem_ready is only looked at while an access is in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:    state_d = arb_pick(if_req, dm_req, starve_force);
            ARB_IF_BUSY: if (mem_ready) state_d = ARB_IDLE;
            ARB_DM_BUSY: if (mem_ready) state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    assign grant_if = (state_q == ARB_IDLE) && (state_d == ARB_IF_BUSY);
    assign grant_dm = (state_q == ARB_IDLE) && (state_d == ARB_DM_BUSY);
    assign if_done  = (state_q == ARB_IF_BUSY) && mem_ready;
    assign dm_done  = (state_q == ARB_DM_BUSY) && mem_ready;

    // FSM outputs: strobe for every busy cycle, writes only for a data store,
    // fetches always read a full word.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_size = size_q;
        case (state_q)
            ARB_IF_BUSY: begin
                mem_en   = 1'b1;
                mem_size = SIZE_WORD;
            end
            ARB_DM_BUSY: begin
                mem_en = 1'b1;
                mem_we = we_q;
            end
            default: ;
        endcase
    end

    // Capture the winner's request so the memory sees stable values even if
    // the requester changes its inputs after the grant.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        we_d    = we_q;
        if (grant_dm) begin
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
            size_d  = dm_size;
            we_d    = dm_we;
        end else if (grant_if) begin
            addr_d  = if_addr;
            wdata_d = '0;
            size_d  = SIZE_WORD;
            we_d    = 1'b0;
        end
    end

    // Completion: one-cycle valid for the owner and registered read data,
    // which then holds until the owner's next completion.
    always_comb begin
        if_valid_d = if_done;
        dm_valid_d = dm_done;
        if_rdata_d = if_done ? mem_rdata : if_rdata_q;
        dm_rdata_d = dm_done ? mem_rdata : dm_rdata_q;
    end

    // Captured request and response registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            we_q       <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            we_q       <= we_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    assign if_stall  = if_req & ~if_valid_q;
    assign dm_stall  = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter.
// Directed vector table, multi-cycle corner sequences, then randomized traffic
// compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned STARVE_MAX = 4;
    localparam int OWN_IF = 1;
    localparam int OWN_DM = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [1:0]  dm_size;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_size(dm_size),
        .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        if_req    = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Directed vectors: inputs for one cycle and the outputs expected in it.
    typedef struct {
        logic [31:0] rst_n, ifr, dmr, dmwe, rdy;
        logic [31:0] ifa, dma, dmwd, mrd, dsz;
        logic [31:0] e_en, e_we, chk_bus, chk_wd, e_addr, e_wd, e_sz;
        logic [31:0] e_ifv, e_dmv, e_ifs, e_dms, e_ifrd, e_dmrd;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl[NV];

    // Reference model: the transaction currently owning the port, the
    // completion being reported this cycle and the last read data per side.
    typedef struct {
        int          owner;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        we;
    } txn_t;

    txn_t        m_cur;
    int          m_pulse;
    logic [31:0] m_ifrd, m_dmrd;
    int          m_streak;
    bit          m_fresh;

    task automatic model_reset();
        m_cur    = '{0, 32'h0, 32'h0, 2'b00, 1'b0};
        m_pulse  = 0;
        m_ifrd   = 32'h0;
        m_dmrd   = 32'h0;
        m_streak = 0;
        m_fresh  = 1'b1;
    endtask

    // Advance the model by one clock edge using the inputs presented now.
    task automatic model_step();
        bit fetch_wins;
        if (!reset) begin
            model_reset();
        end else begin
            m_pulse = 0;
            if (m_cur.owner != 0) begin
                if (mem_ready) begin
                    m_pulse = m_cur.owner;
                    if (m_cur.owner == OWN_IF) m_ifrd = mem_rdata;
                    else                       m_dmrd = mem_rdata;
                    m_cur.owner = 0;
                end
            end else begin
                fetch_wins = if_req && (!dm_req || (GUARD && (m_streak >= int'(STARVE_MAX))));
                if (fetch_wins) begin
                    m_cur.owner = OWN_IF;
                    m_cur.addr  = if_addr;
                    m_cur.size  = 2'b10;
                    m_cur.we    = 1'b0;
                    m_streak    = 0;
                    m_fresh     = 1'b0;
                end else if (dm_req) begin
                    m_cur    = '{OWN_DM, dm_addr, dm_wdata, dm_size, dm_we};
                    if (if_req) m_streak++;
                    m_fresh  = 1'b0;
                end
            end
        end
    endtask

    task automatic model_check();
        logic [1:0] exp_sz;
        chk1("rnd_mem_en", mem_en, m_cur.owner != 0);
        chk1("rnd_mem_we", mem_we, (m_cur.owner == OWN_DM) && m_cur.we);
        chk1("rnd_if_valid", if_valid, m_pulse == OWN_IF);
        chk1("rnd_dm_valid", dm_valid, m_pulse == OWN_DM);
        chk1("rnd_if_stall", if_stall, if_req && (m_pulse != OWN_IF));
        chk1("rnd_dm_stall", dm_stall, dm_req && (m_pulse != OWN_DM));
        chk32("rnd_if_rdata", if_rdata, m_ifrd);
        chk32("rnd_dm_rdata", dm_rdata, m_dmrd);
        if (m_cur.owner != 0 || m_fresh) begin
            exp_sz = (m_cur.owner == OWN_IF) ? 2'b10 : m_cur.size;
            chk32("rnd_mem_addr", mem_addr, m_cur.addr);
            chk32("rnd_mem_size", {30'h0, mem_size}, {30'h0, exp_sz});
        end
        if (((m_cur.owner == OWN_DM) && m_cur.we) || m_fresh)
            chk32("rnd_mem_wdata", mem_wdata, m_cur.wdata);
    endtask

    // Protocol-following random requesters, randomized memory and rare resets.
    task automatic drive_random();
        if (if_req) begin
            if (m_pulse == OWN_IF) begin
                if ($urandom_range(0, 1) == 0) if_req = 1'b0;
                else                          if_addr = $urandom;
            end else if ($urandom_range(0, 99) < 4) begin
                if_req = 1'b0;
            end
        end else if ($urandom_range(0, 99) < 30) begin
            if_req  = 1'b1;
            if_addr = $urandom;
        end
        if (dm_req) begin
            if (m_pulse == OWN_DM) begin
                if ($urandom_range(0, 1) == 0) begin
                    dm_req = 1'b0;
                end else begin
                    dm_addr  = $urandom;
                    dm_wdata = $urandom;
                    dm_we    = 1'($urandom_range(0, 1));
                    dm_size  = 2'($urandom_range(0, 2));
                end
            end else if ($urandom_range(0, 99) < 4) begin
                dm_req = 1'b0;
            end else if ($urandom_range(0, 99) < 15) begin
                dm_addr = $urandom;
            end
        end else if ($urandom_range(0, 99) < 30) begin
            dm_req   = 1'b1;
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            dm_we    = 1'($urandom_range(0, 1));
            dm_size  = 2'($urandom_range(0, 2));
        end
        mem_ready = ($urandom_range(0, 99) < 40);
        mem_rdata = $urandom;
        reset     = ($urandom_range(0, 99) < 1) ? 1'b0 : 1'b1;
    endtask

    int          en_cnt, vcnt, post, ng, ifv_cnt;
    bit          done, prev_en;
    int          got_own[6];
    int          exp_own[6];

    initial begin
        reset = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; dm_size = '0; mem_rdata = '0; mem_ready = 1'b0;

        //               rst ifr dmr we rdy ifa     dma     dmwd          mrd           dsz en we cb cw addr    wd            sz ifv dmv ifs dms ifrd          dmrd
        tbl[0]  = '{0, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,        32'h0,        0, 0, 0, 1, 1, 32'h0,   32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0};
        tbl[1]  = '{1, 1, 0, 0, 0, 32'h100, 32'h0,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 1, 0, 32'h0,        32'h0};
        tbl[2]  = '{1, 1, 0, 0, 1, 32'h100, 32'h0,  32'h0,        32'h20010005, 0, 1, 0, 1, 0, 32'h100, 32'h0,        2, 0, 0, 1, 0, 32'h0,        32'h0};
        tbl[3]  = '{1, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 1, 0, 0, 0, 32'h20010005, 32'h0};
        tbl[4]  = '{1, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 0, 32'h20010005, 32'h0};
        tbl[5]  = '{1, 1, 1, 1, 0, 32'h200, 32'h40, 32'hDEADBEEF, 32'h0,        2, 0, 0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 1, 1, 32'h20010005, 32'h0};
        tbl[6]  = '{1, 1, 1, 1, 1, 32'h200, 32'h40, 32'hDEADBEEF, 32'h0BADF00D, 2, 1, 1, 1, 1, 32'h40,  32'hDEADBEEF, 2, 0, 0, 1, 1, 32'h20010005, 32'h0};
        tbl[7]  = '{1, 1, 0, 0, 0, 32'h200, 32'h0,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 0, 1, 1, 0, 32'h20010005, 32'h0BADF00D};
        tbl[8]  = '{1, 1, 0, 0, 1, 32'h200, 32'h0,  32'h0,        32'h11223344, 0, 1, 0, 1, 0, 32'h200, 32'h0,        2, 0, 0, 1, 0, 32'h20010005, 32'h0BADF00D};
        tbl[9]  = '{1, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 1, 0, 0, 0, 32'h11223344, 32'h0BADF00D};
        tbl[10] = '{1, 0, 1, 0, 0, 32'h0,   32'h43, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 1, 32'h11223344, 32'h0BADF00D};
        tbl[11] = '{1, 0, 1, 0, 0, 32'h0,   32'h99, 32'h0,        32'h0,        0, 1, 0, 1, 0, 32'h43,  32'h0,        0, 0, 0, 0, 1, 32'h11223344, 32'h0BADF00D};
        tbl[12] = '{1, 0, 1, 0, 1, 32'h0,   32'h77, 32'h0,        32'hCAFEF00D, 2, 1, 0, 1, 0, 32'h43,  32'h0,        0, 0, 0, 0, 1, 32'h11223344, 32'h0BADF00D};
        tbl[13] = '{1, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 0, 1, 0, 0, 32'h11223344, 32'hCAFEF00D};
        tbl[14] = '{1, 0, 1, 1, 0, 32'h0,   32'h80, 32'h12345678, 32'h0,        2, 0, 0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 1, 32'h11223344, 32'hCAFEF00D};
        tbl[15] = '{0, 0, 1, 1, 0, 32'h0,   32'h80, 32'h12345678, 32'h0,        2, 1, 1, 1, 1, 32'h80,  32'h12345678, 2, 0, 0, 0, 1, 32'h11223344, 32'hCAFEF00D};
        tbl[16] = '{1, 0, 0, 0, 1, 32'h0,   32'h0,  32'h0,        32'hFFFFFFFF, 0, 0, 0, 1, 1, 32'h0,   32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0};
        tbl[17] = '{1, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,        32'h0,        0, 0, 0, 1, 1, 32'h0,   32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0};

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            reset     = tbl[i].rst_n[0];
            if_req    = tbl[i].ifr[0];
            dm_req    = tbl[i].dmr[0];
            dm_we     = tbl[i].dmwe[0];
            mem_ready = tbl[i].rdy[0];
            if_addr   = tbl[i].ifa;
            dm_addr   = tbl[i].dma;
            dm_wdata  = tbl[i].dmwd;
            mem_rdata = tbl[i].mrd;
            dm_size   = tbl[i].dsz[1:0];
            @(negedge clk);
            chk1($sformatf("v%0d_mem_en", i), mem_en, tbl[i].e_en[0]);
            chk1($sformatf("v%0d_mem_we", i), mem_we, tbl[i].e_we[0]);
            chk1($sformatf("v%0d_if_valid", i), if_valid, tbl[i].e_ifv[0]);
            chk1($sformatf("v%0d_dm_valid", i), dm_valid, tbl[i].e_dmv[0]);
            chk1($sformatf("v%0d_if_stall", i), if_stall, tbl[i].e_ifs[0]);
            chk1($sformatf("v%0d_dm_stall", i), dm_stall, tbl[i].e_dms[0]);
            chk32($sformatf("v%0d_if_rdata", i), if_rdata, tbl[i].e_ifrd);
            chk32($sformatf("v%0d_dm_rdata", i), dm_rdata, tbl[i].e_dmrd);
            if (tbl[i].chk_bus[0]) begin
                chk32($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
                chk32($sformatf("v%0d_mem_size", i), {30'h0, mem_size}, tbl[i].e_sz);
            end
            if (tbl[i].chk_wd[0])
                chk32($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].e_wd);
            @(posedge clk);
            #1;
        end

        // Load whose memory completes in the third busy cycle.
        do_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_size = 2'b10; mem_rdata = 32'h5A5A0003;
        en_cnt = 0; vcnt = 0; post = 0; done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (mem_en) en_cnt++;
            if (dm_valid) begin
                vcnt++;
                dm_req = 1'b0;
            end
            mem_ready = mem_en && (en_cnt == 3);
            @(negedge clk);
            chk1("ld_dm_stall", dm_stall, vcnt == 0);
            @(posedge clk);
            #1;
            if (vcnt > 0) begin
                post++;
                if (post >= 3) done = 1'b1;
            end
        end
        chk1("ld_timeout", done, 1'b1);
        chk32("ld_mem_en_cycles", en_cnt, 3);
        chk32("ld_dm_valid_pulses", vcnt, 1);
        chk32("ld_dm_rdata", dm_rdata, 32'h5A5A0003);

        // Both sides hold their requests; memory is always ready.
        do_reset();
        if_req = 1'b1; if_addr = 32'h1000;
        dm_req = 1'b1; dm_addr = 32'h2000; dm_we = 1'b0; dm_size = 2'b10;
        mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            got_own[k] = 0;
            exp_own[k] = (GUARD && (k == int'(STARVE_MAX))) ? OWN_IF : OWN_DM;
        end
        ng = 0; prev_en = 1'b0; ifv_cnt = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            if (mem_en && !prev_en) begin
                got_own[ng] = (mem_addr == 32'h2000) ? OWN_DM : OWN_IF;
                ng++;
            end
            prev_en = mem_en;
            if (if_valid) ifv_cnt++;
            @(posedge clk);
            #1;
        end
        chk32("starve_grant_count", ng, 6);
        for (int k = 0; k < 6; k++)
            chk32($sformatf("starve_grant%0d_owner", k), got_own[k], exp_own[k]);
        chk32("starve_if_valid_pulses", ifv_cnt, GUARD ? 1 : 0);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            @(negedge clk);
            model_check();
            model_step();
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter STARVE_MAX, default 4, max consecutive data-side grants while fetch waits (used only under REQ-027).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low; state clears on rising clk edge while reset==0.
REQ-005 if_req  in  1  fetch request; held high until if_valid.
REQ-006 if_addr  in  [0:ADDR_W-1]  fetch byte address.
REQ-007 if_valid  out  1  one-cycle pulse: if_rdata valid.
REQ-008 if_rdata  out  [0:31]  fetched instruction word.
REQ-009 dm_req, dm_we  in  1 each  data request; write enable; held until dm_valid.
REQ-010 dm_addr  in  [0:ADDR_W-1]; dm_wdata  in  [0:31]; dm_size  in  [0:1] (00 byte, 01 half, 10 word).
REQ-011 dm_valid  out  1  one-cycle pulse: data access complete; dm_rdata  out  [0:31] valid on loads.
REQ-012 if_stall, dm_stall  out  1 each  requester waiting (req high, valid low).
REQ-013 mem_en, mem_we  out  1 each  shared-memory strobe and write enable.
REQ-014 mem_addr  out  [0:ADDR_W-1]; mem_wdata  out  [0:31]; mem_size  out  [0:1].
REQ-015 mem_rdata  in  [0:31]; mem_ready  in  1  memory completes access in cycle mem_ready==1.

Function
REQ-016 FSM states IDLE, IF_BUSY, DM_BUSY; exactly one transaction in flight.
REQ-017 IDLE, only if_req -> IF_BUSY; only dm_req -> DM_BUSY; both -> DM_BUSY (data priority, lets pipeline drain).
REQ-018 On grant, address/wdata/size/we captured into registers; mem_* driven from registers, not live inputs.
REQ-019 mem_en high for every cycle in IF_BUSY/DM_BUSY, low in IDLE; mem_we high only in DM_BUSY with captured dm_we; IF_BUSY forces mem_size=10, mem_we=0.
REQ-020 Busy state with mem_ready==1: next cycle returns IDLE; valid pulse for owner asserted that next cycle with rdata registered from mem_rdata.
REQ-021 Minimum latency grant-to-valid = 2 cycles (mem_ready in first busy cycle); one IDLE cycle between back-to-back transactions.
REQ-022 mem_ready sampled only in busy states; ignored in IDLE.
REQ-023 if_rdata/dm_rdata hold last value between pulses; dm_rdata updated on stores with mem_rdata (don't-care).
REQ-024 if_stall = if_req & ~if_valid; dm_stall = dm_req & ~dm_valid; combinational.
REQ-025 Requester dropping req mid-transaction: transaction still completes, valid pulse still emitted.

Reset
REQ-026 reset==0 at any edge, including mid-transaction: state IDLE, mem_en/mem_we/if_valid/dm_valid=0, captured registers and rdata=0, starvation counter=0; pending memory completion discarded.

Configuration
REQ-027 Macro MEM_ARB_STARVE_GUARD_EN defined: counter increments on each DM grant while if_req high, clears on IF grant; at count==STARVE_MAX with both requesting, IF granted. Undefined: pure data priority per REQ-017, no counter logic.

Structure
REQ-028 Shared package holds state encoding (IDLE=00, IF_BUSY=01, DM_BUSY=10) and size codes (BYTE, HALF, WORD).
REQ-029 Single module, no sub-modules; optional sub-module arb_starve_ctr for REQ-027 counter.

Verification
REQ-030 if_req, if_addr=0x100, mem_ready same cycle with mem_rdata=0x20010005 -> mem_en 1 cycle, if_valid next cycle, if_rdata=0x20010005.
REQ-031 Both req same cycle, dm_we=1, dm_addr=0x40, wdata=0xDEADBEEF -> store first (mem_we=1, mem_addr=0x40), fetch granted after IDLE cycle.
REQ-032 Load, mem_ready delayed 3 cycles -> mem_en high 3 cycles, dm_stall high until dm_valid, dm_valid single pulse.
REQ-033 reset=0 during DM_BUSY, mem_ready next cycle -> no dm_valid, all outputs 0, IDLE.
REQ-034 With MEM_ARB_STARVE_GUARD_EN, STARVE_MAX=4, both held high -> 4 DM grants then IF grant; without macro -> IF never granted while dm_req high.
REQ-035 dm_size=00, dm_addr=0x43 -> mem_size=00, mem_addr=0x43 unchanged through transaction despite dm_addr changing after grant.
